// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot or periodic reload.
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   load     : capture load_val into count and the reload register
//   load_val : countdown start value
//   en       : decrement enable (0 pauses)
//   count    : registered counter value
//   busy     : high while running
//   done     : registered single-cycle terminal pulse
//   zero     : combinational count == 0
module countdown_timer #(
    parameter int WIDTH       = 8,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] rl, rl_n, count_n;
    logic done_n, rst_n;
    // flops clear on an active-low net derived from the external reset
    assign rst_n = ~reset;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            rl    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            rl    <= rl_n;
            done  <= done_n;
        end
    end
    always_comb begin
        state_n = state;
        count_n = count;
        rl_n    = rl;
        done_n  = 1'b0;
        if (load) begin
            count_n = load_val;
            rl_n    = load_val;
            state_n = (load_val != '0) ? RUN : IDLE;
        end else if (state == RUN && en) begin
            if (count > WIDTH'(1)) begin
                count_n = count - 1'b1;
            end else if (count == WIDTH'(1)) begin
                // terminal step: pulse done, then either restart from rl or stop at 0
                done_n  = 1'b1;
                count_n = (AUTO_RELOAD != 0) ? rl : '0;
                state_n = (AUTO_RELOAD != 0) ? RUN : IDLE;
            end
        end
    end
    assign busy = (state == RUN);
    assign zero = (count == '0);
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: vector-table and scoreboard bench for countdown_timer.
module tb_countdown_timer;
    logic clk = 1'b0;
    logic reset, load, en;
    logic [7:0] load_val;
    logic [7:0] count0, count1;
    logic busy0, busy1, done0, done1, zero0, zero1;
    always #5 clk = ~clk;
    countdown_timer #(.WIDTH(8), .AUTO_RELOAD(0)) u_one (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
        .count(count0), .busy(busy0), .done(done0), .zero(zero0)
    );
    countdown_timer #(.WIDTH(8), .AUTO_RELOAD(1)) u_rel (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
        .count(count1), .busy(busy1), .done(done1), .zero(zero1)
    );
    typedef struct packed {
        logic       ar;
        logic       load;
        logic [7:0] val;
        logic       en;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic       zero;
    } vec_t;
    vec_t vecs[$];
    vec_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    function automatic vec_t mk(input logic ar, input logic ld, input int val, input logic e,
                                input int c, input logic b, input logic d, input logic z);
        vec_t x;
        x.ar = ar; x.load = ld; x.val = val[7:0]; x.en = e;
        x.cnt = c[7:0]; x.busy = b; x.done = d; x.zero = z;
        return x;
    endfunction
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask
    task automatic step(input vec_t x, input string nm);
        vec_t e;
        @(negedge clk);
        load = x.load; load_val = x.val; en = x.en;
        sb.push_back(x);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({nm, " count"}, e.ar ? int'(count1) : int'(count0), int'(e.cnt));
        chk({nm, " busy"},  e.ar ? int'(busy1)  : int'(busy0),  int'(e.busy));
        chk({nm, " done"},  e.ar ? int'(done1)  : int'(done0),  int'(e.done));
        chk({nm, " zero"},  e.ar ? int'(zero1)  : int'(zero0),  int'(e.zero));
    endtask
    initial begin
        // one-shot countdown from 5
        vecs.push_back(mk(0, 1, 5, 1, 5, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
        // pause
        vecs.push_back(mk(0, 1, 3, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1));
        // periodic reload of 4
        vecs.push_back(mk(1, 1, 4, 1, 4, 1, 0, 0));
        for (int i = 1; i <= 12; i++)
            vecs.push_back(mk(1, 0, 0, 1, (i % 4 == 0) ? 4 : 4 - (i % 4), 1, i % 4 == 0, 0));
        // load collides with count == 1
        vecs.push_back(mk(0, 1, 2, 1, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7, 1, 7, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 6, 1, 0, 0));
        // zero load, from idle and while running
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 3, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
        // reload with N == 1 keeps done high while enabled
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0));
        reset = 1'b1; load = 1'b0; en = 1'b0; load_val = 8'd0;
        #12;
        chk("reset count0", int'(count0), 0);
        chk("reset busy0", int'(busy0), 0);
        chk("reset done0", int'(done0), 0);
        chk("reset count1", int'(count1), 0);
        chk("reset busy1", int'(busy1), 0);
        chk("reset zero1", int'(zero1), 1);
        @(negedge clk);
        reset = 1'b0;
        step(mk(0, 0, 0, 1, 0, 0, 0, 1), "post_reset_idle");
        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));
        // full-range countdown from 255
        step(mk(0, 1, 255, 1, 255, 1, 0, 0), "max_load");
        for (int i = 1; i <= 255; i++)
            step(mk(0, 0, 0, 1, 255 - i, i != 255, i == 255, i == 255), $sformatf("max%0d", i));
        // asynchronous reset between edges at count == 2
        step(mk(0, 1, 4, 1, 4, 1, 0, 0), "ar_load");
        step(mk(0, 0, 0, 1, 3, 1, 0, 0), "ar_3");
        step(mk(0, 0, 0, 1, 2, 1, 0, 0), "ar_2");
        #3 reset = 1'b1;
        #1;
        chk("async count", int'(count0), 0);
        chk("async busy", int'(busy0), 0);
        chk("async done", int'(done0), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(mk(0, 0, 0, 1, 0, 0, 0, 1), $sformatf("after_reset%0d", i));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter width in bits.
REQ-002 The block SHALL have parameter AUTO_RELOAD, default 0: 0 = one-shot, 1 = periodic reload.
REQ-003 Port clk SHALL be an input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-005 Port load SHALL be an input, 1 bit: capture load_val this cycle.
REQ-006 Port load_val SHALL be an input, WIDTH bits: start value for the countdown.
REQ-007 Port en SHALL be an input, 1 bit: decrement enable; en=0 pauses the count.
REQ-008 Port count SHALL be an output, WIDTH bits: current counter value, registered.
REQ-009 Port busy SHALL be an output, 1 bit: high while the state is RUN.
REQ-010 Port done SHALL be an output, 1 bit: registered, single-cycle terminal pulse.
REQ-011 Port zero SHALL be an output, 1 bit: combinational (count == 0).

Function
REQ-012 The block SHALL implement states IDLE and RUN, plus a WIDTH-bit reload register rl.
REQ-013 When load=1 in any state, the block SHALL set count <= load_val and rl <= load_val.
REQ-014 On a load with load_val != 0, the next state SHALL be RUN.
REQ-015 On a load with load_val == 0, the next state SHALL be IDLE and done SHALL stay 0.
REQ-016 In RUN with load=0, en=1 and count > 1, the block SHALL set count <= count - 1.
REQ-017 In RUN with load=0, en=1 and count == 1, the block SHALL assert done=1 for exactly the following cycle.
REQ-018 In the REQ-017 case with AUTO_RELOAD=0, the block SHALL set count <= 0 and state <= IDLE.
REQ-019 In the REQ-017 case with AUTO_RELOAD=1, the block SHALL set count <= rl and remain in RUN.
REQ-020 In RUN with en=0 and load=0, count, state and rl SHALL hold, and done SHALL be 0.
REQ-021 In IDLE without load, count SHALL hold; the counter SHALL never decrement below 0 (no underflow wrap).
REQ-022 Load SHALL take priority over decrement and terminal detection; a load coinciding with count == 1 and en=1 SHALL produce no done pulse.
REQ-023 Latency: from a load cycle with value N > 0 and en held at 1, done SHALL be high on the Nth rising edge after the load edge.
REQ-024 With AUTO_RELOAD=1 and en held at 1, done SHALL pulse with period N cycles.
REQ-025 The decrement SHALL be modulo-free WIDTH-bit arithmetic; load_val = 2^WIDTH-1 SHALL count down fully.
REQ-026 done SHALL never be high for two consecutive cycles when N > 1; with AUTO_RELOAD=1 and N == 1, done SHALL stay high continuously while en=1.
REQ-027 busy SHALL equal (state == RUN), registered.

Reset
REQ-028 While reset=1, the block SHALL immediately force count=0, rl=0, state=IDLE, busy=0 and done=0, independent of clk.
REQ-029 Reset asserted mid-countdown SHALL abort the countdown with no done pulse.
REQ-030 After reset deassertion the block SHALL remain in IDLE until a load.
REQ-031 Reset SHALL be released synchronously to clk by the surrounding logic; internal flops SHALL use active-low clear, driven from an inverted reset.

Verification
REQ-032 The bench SHALL check one-shot: AUTO_RELOAD=0, load 5 with en=1 -> count 4,3,2,1,0, done high exactly at count=0, busy 1->0, then count holds at 0.
REQ-033 The bench SHALL check pause: load 3, en=1 for 1 cycle, en=0 for 4 cycles, then en=1 -> count 2 held for 4 cycles, done 2 cycles after re-enable.
REQ-034 The bench SHALL check reload: AUTO_RELOAD=1, load 4, en=1 for 12 cycles -> done pulses at cycles 4, 8 and 12, and count sequence 3,2,1,4,... with no 0 ever shown.
REQ-035 The bench SHALL check load collision: during a count of 1 with en=1, load 7 -> count=7, no done pulse, busy stays 1.
REQ-036 The bench SHALL check zero load and extremes: load 0 -> IDLE, zero=1, no done; load 255 (WIDTH=8) -> done after exactly 255 cycles.
REQ-037 The bench SHALL check async reset: assert reset between clock edges at count=2 -> count=0, busy=0 and done=0 before the next edge; no done follows.
